// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: request opcodes,
// ALU control codes and FSM states, plus the opcode-to-ALU map.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLL = 3'b010,
    OP_SRL = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_MUL = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_SRL = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [3:0] op_ctrl(op_e op);
    logic [3:0] c;
    c = ALU_ADD;
    case (op)
      OP_SUB:  c = ALU_SUB;
      OP_SLL:  c = ALU_SLL;
      OP_SRL:  c = ALU_SRL;
      OP_AND:  c = ALU_AND;
      OP_OR:   c = ALU_OR;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences single-step ALU ops and a shift-add multiply over an
// external peer ALU (alu_* ports); valid/ready request and response.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [n-1:0] req_a,
  input  logic [n-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_data,
  output logic         rsp_zero,
  output logic [n-1:0] alu_srca,
  output logic [n-1:0] alu_srcb,
  output logic [3:0]   alu_alucontrol,
  input  logic [n-1:0] alu_aluout
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [n-1:0]   a_q, a_d;
  logic [n-1:0]   b_q, b_d;
  logic [n-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [n-1:0]   data_q, data_d;
  logic           zero_q, zero_d;
  logic [n-1:0]   res;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    zero_d         = zero_q;
    res            = '0;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    alu_srca       = '0;
    alu_srcb       = '0;
    alu_alucontrol = ALU_ADD;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d  = op_e'(req_op);
          a_d   = req_a;
          b_d   = req_b;
          acc_d = '0;
          cnt_d = '0;
          if (op_e'(req_op) == OP_MUL) state_d = S_MUL;
          else state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Illegal op leaves the ALU idle and yields a zero result.
        if (op_q != OP_ILL) begin
          alu_srca       = a_q;
          alu_srcb       = b_q;
          alu_alucontrol = op_ctrl(op_q);
          res            = alu_aluout;
        end
        data_d  = res;
        zero_d  = (res == '0);
        state_d = S_DONE;
      end
      S_MUL: begin
        // One partial product per cycle, summed through the peer ALU.
        alu_srca = acc_q;
        alu_srcb = b_q[cnt_q] ? (a_q << cnt_q) : '0;
        acc_d    = alu_aluout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(n - 1)) begin
          data_d  = alu_aluout;
          zero_d  = (alu_aluout == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_data = data_q;
  assign rsp_zero = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural peer ALU.
// Hand-computed expectations; one summary line at the end.
module tb_alu_sequencer;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [3:0]  alu_alucontrol;
  logic [31:0] alu_aluout;

  int n_tests = 0;
  int n_fail  = 0;

  alu_sequencer #(.n(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_a          (req_a),
    .req_b          (req_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_zero       (rsp_zero),
    .alu_srca       (alu_srca),
    .alu_srcb       (alu_srcb),
    .alu_alucontrol (alu_alucontrol),
    .alu_aluout     (alu_aluout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    alu_aluout = '0;
    case (alu_alucontrol)
      4'b0000: alu_aluout = alu_srca + alu_srcb;
      4'b0001: alu_aluout = alu_srca - alu_srcb;
      4'b0010: alu_aluout = alu_srca << alu_srcb;
      4'b0011: alu_aluout = alu_srca >> alu_srcb;
      4'b0100: alu_aluout = alu_srca & alu_srcb;
      4'b0101: alu_aluout = alu_srca | alu_srcb;
      default: alu_aluout = '0;
    endcase
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request across one edge (E0); returns at E0+#1.
  task automatic send(input logic [2:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h1234_5678;
  endtask

  // Complete the response handshake and confirm return to IDLE.
  task automatic ack(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_idle_rdy"}, 64'(req_ready), 64'd1);
    check({tag, "_idle_vld"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic bad;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    @(negedge clk);
    check("rst_vld",  64'(rsp_valid), 64'd0);
    check("rst_data", 64'(rsp_data), 64'd0);
    check("rst_zero", 64'(rsp_zero), 64'd0);
    check("rst_srca", 64'(alu_srca), 64'd0);
    check("rst_ctrl", 64'(alu_alucontrol), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", 64'(req_ready), 64'd1);

    // add 5+7
    send(3'b000, 32'd5, 32'd7);
    check("add_ctrl", 64'(alu_alucontrol), 64'h0);
    check("add_srca", 64'(alu_srca), 64'd5);
    check("add_srcb", 64'(alu_srcb), 64'd7);
    check("add_e0vld", 64'(rsp_valid), 64'd0);
    check("add_rdy", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("add_vld", 64'(rsp_valid), 64'd1);
    check("add_data", 64'(rsp_data), 64'd12);
    check("add_zero", 64'(rsp_zero), 64'd0);
    check("add_dsrc", 64'(alu_srca), 64'd0);
    ack("add");

    // sub 9-9
    send(3'b001, 32'd9, 32'd9);
    check("sub_ctrl", 64'(alu_alucontrol), 64'h1);
    @(posedge clk); #1;
    check("sub_data", 64'(rsp_data), 64'd0);
    check("sub_zero", 64'(rsp_zero), 64'd1);
    ack("sub");

    // or
    send(3'b101, 32'h0000_00F0, 32'h0000_000F);
    check("or_ctrl", 64'(alu_alucontrol), 64'h5);
    @(posedge clk); #1;
    check("or_data", 64'(rsp_data), 64'hFF);
    ack("or");

    // sll by 33: full shift amount, result 0
    send(3'b010, 32'd1, 32'd33);
    check("sll_srcb", 64'(alu_srcb), 64'd33);
    check("sll_ctrl", 64'(alu_alucontrol), 64'h2);
    @(posedge clk); #1;
    check("sll_data", 64'(rsp_data), 64'd0);
    check("sll_zero", 64'(rsp_zero), 64'd1);
    ack("sll");

    // mul 0xFFFF * 0x10001, with stray requests held during busy
    send(3'b110, 32'h0000_FFFF, 32'h0001_0001);
    req_valid = 1'b1;
    req_op    = 3'b000;
    bad = 1'b0;
    for (int k = 1; k < 32; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) bad = 1'b1;
    end
    check("mul_busy", 64'(bad), 64'd0);
    @(posedge clk); #1;
    check("mul_vld", 64'(rsp_valid), 64'd1);
    check("mul_rdy", 64'(req_ready), 64'd0);
    check("mul_data", 64'(rsp_data), 64'hFFFF_FFFF);
    check("mul_zero", 64'(rsp_zero), 64'd0);
    req_valid = 1'b0;
    ack("mul");

    // mul overflow: 0x80000000 * 2 -> 0
    send(3'b110, 32'h8000_0000, 32'd2);
    repeat (31) @(posedge clk);
    @(posedge clk); #1;
    check("mulov_vld", 64'(rsp_valid), 64'd1);
    check("mulov_data", 64'(rsp_data), 64'd0);
    check("mulov_zero", 64'(rsp_zero), 64'd1);
    ack("mulov");

    // srl with backpressure
    send(3'b011, 32'h8000_0000, 32'd4);
    check("srl_ctrl", 64'(alu_alucontrol), 64'h3);
    @(posedge clk); #1;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          rsp_data !== 32'h0800_0000 || rsp_zero !== 1'b0)
        bad = 1'b1;
    end
    check("bp_hold", 64'(bad), 64'd0);
    check("bp_data", 64'(rsp_data), 64'h0800_0000);
    ack("bp");

    // reset mid-mul at count 10: 3*5, acc=15 by then
    send(3'b110, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    check("mrst_srca", 64'(alu_srca), 64'd15);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_vld", 64'(rsp_valid), 64'd0);
    check("mrst_data", 64'(rsp_data), 64'd0);
    check("mrst_srca0", 64'(alu_srca), 64'd0);
    check("mrst_srcb0", 64'(alu_srcb), 64'd0);
    check("mrst_ctrl", 64'(alu_alucontrol), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mrst_rdy", 64'(req_ready), 64'd1);
    send(3'b000, 32'd1, 32'd1);
    @(posedge clk); #1;
    check("mrst_add", 64'(rsp_data), 64'd2);
    ack("mrst");

    // illegal op
    send(3'b111, 32'd3, 32'd4);
    check("ill_srca", 64'(alu_srca), 64'd0);
    check("ill_srcb", 64'(alu_srcb), 64'd0);
    check("ill_ctrl", 64'(alu_alucontrol), 64'd0);
    @(posedge clk); #1;
    check("ill_vld", 64'(rsp_valid), 64'd1);
    check("ill_data", 64'(rsp_data), 64'd0);
    check("ill_zero", 64'(rsp_zero), 64'd1);
    ack("ill");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
